ddr3_ui_sequencer: RTL and testbench

Converts a simple valid/ready request stream (read or write, one 256-bit beat each) into the DDR3 controller user-interface protocol, and returns read data through a bounded response FIFO. Sits directly upstream of the DDR3 controller wrapper in the `ui_clk` domain. Its job is to hide the split command/write-data handshakes (`app_rdy`, `app_wdf_rdy`). The controller has no read-data backpressure, so the block also guarantees that read responses can never overflow.

---
 rtl/ddr3_ui_sequencer.sv | 139 +++++++++++++
 tb/tb_ddr3_ui_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_ui_sequencer.sv
// Request stream to DDR3 controller UI adapter.
// Holds one request, splits cmd/data handshakes, credits reads into a response FIFO.
module ddr3_ui_sequencer #(
    parameter int ADDR_WIDTH = 29,
    parameter int RD_DEPTH   = 8
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [255:0]                  req_data,
    input  logic [31:0]                   req_mask,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [255:0]                  rsp_data,
    output logic [ADDR_WIDTH-1:0]         app_addr,
    output logic [2:0]                    app_cmd,
    output logic                          app_en,
    input  logic                          app_rdy,
    output logic [255:0]                  app_wdf_data,
    output logic [31:0]                   app_wdf_mask,
    output logic                          app_wdf_wren,
    output logic                          app_wdf_end,
    input  logic                          app_wdf_rdy,
    input  logic [255:0]                  app_rd_data,
    input  logic                          app_rd_data_valid,
    input  logic                          init_calib_complete,
    output logic [$clog2(RD_DEPTH+1)-1:0] rd_inflight,
    output logic                          rsp_overflow
);

    localparam int CW = $clog2(RD_DEPTH + 1);
    localparam int PW = $clog2(RD_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(RD_DEPTH);

    logic                  hv;
    logic                  cmd_done;
    logic                  wd_done;
    logic                  h_write;
    logic [ADDR_WIDTH-1:0] h_addr;
    logic [255:0]          h_data;
    logic [31:0]           h_mask;

    logic cmd_fire;
    logic wd_fire;
    logic retire;
    logic req_fire;
    logic rd_fire;
    logic pop;
    logic push_ok;
    logic full;

    logic [255:0]  mem [RD_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    always_comb begin
        app_en       = hv && !cmd_done && (h_write || (rd_inflight < DEPTH_C));
        app_cmd      = {2'b00, hv && !h_write};
        app_addr     = h_addr;
        app_wdf_data = h_data;
        app_wdf_mask = h_mask;
        app_wdf_wren = hv && h_write && !wd_done;
        app_wdf_end  = app_wdf_wren;
        cmd_fire     = app_en && app_rdy;
        wd_fire      = app_wdf_wren && app_wdf_rdy;
        retire       = hv && (cmd_done || cmd_fire) && (wd_done || wd_fire);
        req_ready    = init_calib_complete && (!hv || retire);
        req_fire     = req_valid && req_ready;
        rd_fire      = cmd_fire && !h_write;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hv       <= 1'b0;
            cmd_done <= 1'b0;
            wd_done  <= 1'b0;
            h_write  <= 1'b0;
            h_addr   <= '0;
            h_data   <= '0;
            h_mask   <= '0;
        end else if (req_fire) begin
            hv       <= 1'b1;
            cmd_done <= 1'b0;
            wd_done  <= !req_write;
            h_write  <= req_write;
            h_addr   <= req_addr;
            h_data   <= req_data;
            h_mask   <= req_mask;
        end else if (retire) begin
            hv <= 1'b0;
        end else begin
            if (cmd_fire) cmd_done <= 1'b1;
            if (wd_fire)  wd_done  <= 1'b1;
        end
    end

    // Credits cover both reads in the controller and data parked in the FIFO.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_inflight <= '0;
        end else if (rd_fire && !pop) begin
            rd_inflight <= rd_inflight + 1'b1;
        end else if (!rd_fire && pop) begin
            rd_inflight <= rd_inflight - 1'b1;
        end
    end

    always_comb begin
        full      = (count == DEPTH_C);
        rsp_valid = (count != '0);
        pop       = rsp_valid && rsp_ready;
        push_ok   = app_rd_data_valid && (!full || pop);
        rsp_data  = mem[rd_ptr];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < RD_DEPTH; i++) mem[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rsp_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= app_rd_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop) count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
            if (app_rd_data_valid && full && !pop) rsp_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr3_ui_sequencer.sv
// Directed bench for ddr3_ui_sequencer with a small controller model.
// Controller returns reads five cycles after the command is taken.
module tb_ddr3_ui_sequencer;

    localparam int AW = 29;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [255:0]  req_data;
    logic [31:0]   req_mask;
    logic          rsp_valid, rsp_ready;
    logic [255:0]  rsp_data;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en, app_rdy;
    logic [255:0]  app_wdf_data;
    logic [31:0]   app_wdf_mask;
    logic          app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [255:0]  app_rd_data;
    logic          app_rd_data_valid;
    logic          init_calib_complete;
    logic [3:0]    rd_inflight;
    logic          rsp_overflow;

    logic          m_rv = 1'b0;
    logic [255:0]  m_rd = '0;
    logic          inj_rv;
    logic [255:0]  inj_rd;

    assign app_rd_data_valid = m_rv | inj_rv;
    assign app_rd_data       = inj_rv ? inj_rd : m_rd;

    ddr3_ui_sequencer #(.ADDR_WIDTH(AW), .RD_DEPTH(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .init_calib_complete(init_calib_complete),
        .rd_inflight(rd_inflight), .rsp_overflow(rsp_overflow)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    int n_rdfire = 0;
    logic last_acc;
    logic [255:0] expq [$];
    logic [255:0] shadow [logic [AW-1:0]];
    logic [255:0] cmem [logic [AW-1:0]];
    logic [AW-1:0] q_addr [$];
    int q_due [$];
    int cyc = 0;

    function automatic logic [255:0] dflt(input logic [AW-1:0] a);
        return {8{32'(a) ^ 32'hD00D_0000}};
    endfunction

    function automatic logic [255:0] merge(input logic [255:0] o,
                                           input logic [255:0] n,
                                           input logic [31:0] m);
        logic [255:0] r;
        r = o;
        for (int b = 0; b < 32; b++) if (!m[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    // Controller model: stores written beats, returns reads after a fixed delay.
    always begin
        @(posedge CLK or negedge RST_N);
        if (!RST_N) begin
            q_addr.delete();
            q_due.delete();
            m_rv <= 1'b0;
        end else begin
            logic [255:0] old;
            cyc++;
            if (app_wdf_wren && app_wdf_rdy) begin
                old = cmem.exists(app_addr) ? cmem[app_addr] : dflt(app_addr);
                cmem[app_addr] = merge(old, app_wdf_data, app_wdf_mask);
            end
            if (app_en && app_rdy && app_cmd == 3'b001) begin
                q_addr.push_back(app_addr);
                q_due.push_back(cyc + 5);
            end
            #1;
            m_rv <= 1'b0;
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                logic [AW-1:0] a;
                a = q_addr.pop_front();
                void'(q_due.pop_front());
                m_rv <= 1'b1;
                m_rd <= cmem.exists(a) ? cmem[a] : dflt(a);
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [255:0] o;
        #1;
        last_acc = req_valid && req_ready;
        if (last_acc) begin
            n_acc++;
            if (req_write) begin
                o = shadow.exists(req_addr) ? shadow[req_addr] : dflt(req_addr);
                shadow[req_addr] = merge(o, req_data, req_mask);
            end else begin
                expq.push_back(shadow.exists(req_addr) ? shadow[req_addr]
                                                       : dflt(req_addr));
            end
        end
        if (app_en && app_rdy && app_cmd == 3'b001) n_rdfire++;
        if (rsp_valid && rsp_ready) begin
            chk("rsp_expected", 256'(rsp_valid), 256'(expq.size() != 0));
            if (expq.size() != 0) chk("rsp_order", rsp_data, expq.pop_front());
        end
        @(posedge CLK);
        #2;
    endtask

    initial begin
        int n;
        int idx;
        int gaps;
        RST_N = 1'b0;
        req_valid = 0; req_write = 0; req_addr = '0; req_data = '0; req_mask = '0;
        rsp_ready = 0; app_rdy = 0; app_wdf_rdy = 0; init_calib_complete = 0;
        inj_rv = 0; inj_rd = '0;
        #3;
        chk("rst_req_ready", 256'(req_ready), 0);
        chk("rst_rsp_valid", 256'(rsp_valid), 0);
        chk("rst_app_en", 256'(app_en), 0);
        chk("rst_wren", 256'(app_wdf_wren), 0);
        chk("rst_inflight", 256'(rd_inflight), 0);
        chk("rst_overflow", 256'(rsp_overflow), 0);
        chk("rst_buses", 256'(app_addr) | app_wdf_data | rsp_data, 0);
        @(posedge CLK); #2;
        RST_N = 1'b1;

        // Calibration gate
        req_valid = 1; req_write = 0; req_addr = 29'h10;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("calib_req_ready", 256'(req_ready), 0);
            chk("calib_app_en", 256'(app_en), 0);
            cycle();
        end
        req_valid = 0;

        // Single write then read
        init_calib_complete = 1; app_rdy = 1; app_wdf_rdy = 1; rsp_ready = 1;
        req_valid = 1; req_write = 1; req_addr = 29'h40;
        req_data = {32{8'hA5}}; req_mask = '0;
        #1;
        chk("t1_req_ready", 256'(req_ready), 1);
        cycle();
        req_valid = 0;
        #1;
        chk("t1_wr_en", 256'(app_en), 1);
        chk("t1_wr_cmd", 256'(app_cmd), 0);
        chk("t1_wr_addr", 256'(app_addr), 256'h40);
        chk("t1_wren_end", 256'({app_wdf_wren, app_wdf_end}), 256'b11);
        chk("t1_wdata", app_wdf_data, {32{8'hA5}});
        chk("t1_wmask", 256'(app_wdf_mask), 0);
        cycle();
        chk("t1_wr_once", 256'({app_en, app_wdf_wren}), 0);
        req_valid = 1; req_write = 0; req_addr = 29'h40;
        cycle();
        req_valid = 0;
        #1;
        chk("t1_rd_en", 256'(app_en), 1);
        chk("t1_rd_cmd", 256'(app_cmd), 256'd1);
        n = 0;
        while (!app_rd_data_valid && n < 20) begin cycle(); n++; end
        chk("t1_return_seen", 256'(app_rd_data_valid), 1);
        chk("t1_rsp_not_yet", 256'(rsp_valid), 0);
        cycle();
        chk("t1_rsp_valid", 256'(rsp_valid), 1);
        chk("t1_rsp_data", rsp_data, {32{8'hA5}});
        cycle();
        chk("t1_rsp_done", 256'(rsp_valid), 0);
        chk("t1_inflight0", 256'(rd_inflight), 0);

        // Data before command
        app_rdy = 0; app_wdf_rdy = 1;
        req_valid = 1; req_write = 1; req_addr = 29'h80; req_data = {8{32'h1234_5678}};
        cycle();
        req_valid = 0;
        #1;
        chk("t2a_both", 256'({app_en, app_wdf_wren}), 256'b11);
        cycle();
        for (int i = 0; i < 3; i++) begin
            chk("t2a_en_hold", 256'({app_en, app_wdf_wren}), 256'b10);
            chk("t2a_addr", 256'(app_addr), 256'h80);
            chk("t2a_blocked", 256'(req_ready), 0);
            cycle();
        end
        app_rdy = 1;
        #1;
        chk("t2a_retire", 256'(req_ready), 1);
        cycle();
        chk("t2a_idle", 256'(app_en), 0);

        // Command before data
        app_rdy = 1; app_wdf_rdy = 0;
        req_valid = 1; req_write = 1; req_addr = 29'h84; req_data = {8{32'hCAFE_F00D}};
        cycle();
        req_valid = 0;
        #1;
        chk("t2b_both", 256'({app_en, app_wdf_wren}), 256'b11);
        cycle();
        for (int i = 0; i < 3; i++) begin
            chk("t2b_wren_hold", 256'({app_en, app_wdf_wren}), 256'b01);
            chk("t2b_wdata", app_wdf_data, {8{32'hCAFE_F00D}});
            chk("t2b_blocked", 256'(req_ready), 0);
            cycle();
        end
        app_wdf_rdy = 1;
        #1;
        chk("t2b_retire", 256'(req_ready), 1);
        cycle();
        chk("t2b_idle", 256'(app_wdf_wren), 0);
        req_valid = 1; req_write = 0; req_addr = 29'h80;
        cycle();
        req_addr = 29'h84;
        cycle();
        req_valid = 0;
        for (int i = 0; i < 12; i++) cycle();
        chk("t2_drained", 256'(expq.size()), 0);

        // Credit limit
        rsp_ready = 0; n_acc = 0; n_rdfire = 0;
        for (int i = 0; i < 30; i++) begin
            req_valid = (n_acc < 10); req_write = 0; req_addr = 29'h200 + 29'(n_acc);
            cycle();
        end
        chk("t3_fires8", 256'(n_rdfire), 8);
        chk("t3_inflight8", 256'(rd_inflight), 8);
        chk("t3_accepted9", 256'(n_acc), 9);
        chk("t3_stall", 256'(app_en), 0);
        chk("t3_no_ovf", 256'(rsp_overflow), 0);
        rsp_ready = 1;
        #1;
        chk("t3_head", rsp_data, dflt(29'h200));
        cycle();
        rsp_ready = 0;
        #1;
        chk("t3_release", 256'(app_en), 1);
        chk("t3_inflight7", 256'(rd_inflight), 7);
        for (int i = 0; i < 10; i++) begin
            req_valid = (n_acc < 10); req_addr = 29'h200 + 29'(n_acc);
            cycle();
        end
        chk("t3_fires9", 256'(n_rdfire), 9);
        chk("t3_inflight8b", 256'(rd_inflight), 8);
        rsp_ready = 1; req_valid = 0;
        for (int i = 0; i < 40; i++) cycle();
        chk("t3_fires10", 256'(n_rdfire), 10);
        chk("t3_drained", 256'(expq.size()), 0);
        chk("t3_inflight0", 256'(rd_inflight), 0);

        // Back-to-back alternating stream
        idx = 0; gaps = 0; n = 0;
        while (idx < 64 && n < 200) begin
            req_valid = 1; req_write = (idx % 2 == 0);
            req_addr = 29'h100 + 29'(idx / 2);
            req_data = {8{32'(idx) * 32'h0101_0101 ^ 32'hC0DE_0000}};
            cycle();
            if (last_acc) idx++;
            else gaps++;
            n++;
        end
        req_valid = 0;
        chk("t4_no_gaps", 256'(gaps), 0);
        chk("t4_cycles", 256'(n), 64);
        for (int i = 0; i < 20; i++) cycle();
        chk("t4_drained", 256'(expq.size()), 0);
        chk("t4_inflight0", 256'(rd_inflight), 0);

        // Overflow by injected returns with no credits spent
        rsp_ready = 0;
        for (int i = 0; i < 8; i++) begin
            inj_rv = 1; inj_rd = {8{32'hBEEF_0000 + 32'(i)}};
            cycle();
        end
        inj_rv = 0;
        #1;
        chk("t6_full_no_ovf", 256'(rsp_overflow), 0);
        chk("t6_head", rsp_data, {8{32'hBEEF_0000}});
        inj_rv = 1; inj_rd = {8{32'hDEAD_DEAD}};
        cycle();
        inj_rv = 0;
        #1;
        chk("t6_ovf", 256'(rsp_overflow), 1);
        chk("t6_head_kept", rsp_data, {8{32'hBEEF_0000}});

        // Reset with reads in flight
        n_acc = 0; n_rdfire = 0; n = 0;
        while (n_rdfire < 3 && n < 20) begin
            req_valid = (n_acc < 3); req_write = 0; req_addr = 29'h300 + 29'(n_acc);
            cycle();
            n++;
        end
        req_valid = 0;
        #1;
        chk("t5_inflight3", 256'(rd_inflight), 3);
        RST_N = 0; init_calib_complete = 0;
        #1;
        chk("t5_req_ready", 256'(req_ready), 0);
        chk("t5_rsp_valid", 256'(rsp_valid), 0);
        chk("t5_en_wren", 256'({app_en, app_wdf_wren, app_wdf_end}), 0);
        chk("t5_inflight", 256'(rd_inflight), 0);
        chk("t5_ovf", 256'(rsp_overflow), 0);
        chk("t5_buses", 256'(app_addr) | 256'(app_cmd) | app_wdf_data | rsp_data, 0);
        expq.delete();
        cycle();
        cycle();
        RST_N = 1;
        for (int i = 0; i < 10; i++) cycle();
        chk("t5_post_empty", 256'(rsp_valid), 0);
        chk("t5_post_inflight", 256'(rd_inflight), 0);
        chk("t5_post_ready", 256'(req_ready), 0);
        init_calib_complete = 1;
        #1;
        chk("t5_calib_ready", 256'(req_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
